video_tbl_writer: RTL and testbench
===================================

// Module: video_tbl_writer
// PURPOSE
//  AXI4-Lite initiator that programs a video_tbl_modulator instance over its register port.
//  On a start pulse it writes a saturating linear ramp into the table region, then writes
//  PARAM_END = count. Sits beside the control CPU path for boot-time or no-CPU threshold
//  loading. One write is in flight at a time.
// PARAMETERS
//  ADDR_BITS    6      table index width; table region starts at word address 1<<ADDR_BITS
//  MEM_DEPTH    2**ADDR_BITS  table entries available
//  VALUE_BITS   8      ramp value width; written zero-extended into wdata
//  BASE_ADDR    0      byte base address of the target slave
// PORTS
//  aresetn    in   1           asynchronous active-low reset
//  aclk       in   1           single clock; m_axi4l must be clocked by aclk
//  start      in   1           1-cycle request; ignored while busy
//  cfg_base   in   VALUE_BITS  ramp value of entry 0
//  cfg_step   in   VALUE_BITS  increment per entry
//  cfg_count  in   ADDR_BITS   last entry index; writes entries 0..cfg_count
//  busy       out  1           high from the cycle after an accepted start until done
//  done       out  1           1-cycle pulse at the end of a sequence (normal or aborted)
//  error      out  1           sticky; cleared by an accepted start
//  m_axi4l    jelly3_axi4l_if.m   write and read channels used; interface aresetn unused
// BEHAVIOUR
//  - Reset (async): state IDLE; awvalid, wvalid, bready, arvalid, rready, busy, done, error = 0.
//  - start in IDLE: latch cfg_*; clear error; set idx=0 and val=cfg_base. Next state is WR.
//  - WR: assert awvalid and wvalid together in the same cycle.
//    - Each valid drops independently when its ready is sampled high.
//    - awaddr, wdata and wstrb stay stable until their own channel handshakes.
//    - When both channels have handshaked, go to WB with bready=1.
//  - WB: wait for bvalid.
//    - bresp != 0: set error, go to FIN (no further writes).
//    - bresp == 0, table phase, idx < count: idx++; val = min(val+step, 2^VALUE_BITS-1); go to WR.
//    - bresp == 0, table phase, idx == count: go to WR with the PARAM_END phase.
//    - bresp == 0, PARAM_END phase: go to FIN.
//  - Table write address: awaddr = BASE_ADDR + ((1<<ADDR_BITS)+idx)*STRB_BITS.
//    wdata = val zero-extended; wstrb = all ones; awprot = 0.
//  - PARAM_END write: awaddr = BASE_ADDR + 4*STRB_BITS; wdata = count.
//  - Saturation: the add is done VALUE_BITS+1 wide and clamped, so the ramp never wraps.
//  - FIN: done=1 for one cycle and busy=0; next state is IDLE.
//    - Latency after an accepted start, zero-wait slave: (count+2) write transactions of 2 cycles each, +1 cycle.
//  - start during busy: no effect.
//  - count = MEM_DEPTH-1: all entries are written; idx must not overflow.
//  - AW accepted several cycles before W, or the reverse: exactly one B is consumed per write.
//  - Reset mid-transaction: all valids deassert immediately. The slave is reset with the same aresetn.
// CONFIGURATION
//  VIDEO_TBL_WRITER_READBACK_EN
//  - Defined: after a clean PARAM_END write, enter RD and read back entries 0..count.
//    - arvalid is held until arready; then rready=1 until rvalid.
//    - The expected value is regenerated with the same ramp and compared on the low VALUE_BITS bits.
//    - Any mismatch or rresp != 0 sets error; the remaining reads still complete; then go to FIN.
//  - Undefined: the read channel is tied off (arvalid=0, rready=0); no RD states exist;
//    the sequence goes from PARAM_END straight to FIN.
// STRUCTURE
//  - Package video_tbl_pkg:
//    - REGADR_CORE_ID, REGADR_PARAM_END (4), REGADR_PARAM_INV (5);
//    - function regadr_tbl_start(ADDR_BITS);
//    - state_t enum {IDLE, WR, WB, RA, RD, FIN}.
//  - Sub-module video_tbl_ramp_gen: init/step/saturate value generator, shared by the write and readback paths.
// TESTING
//  (BASE_ADDR=0, ADDR_BITS=6, STRB_BITS=4)
//  - base=0, step=4, count=3 -> writes 0x100/0, 0x104/4, 0x108/8, 0x10C/12, then 0x010/3;
//    done pulses once; error=0.
//  - base=250, step=3, count=2 -> table data 250, 253, 255 (saturated); PARAM_END=2.
//  - awready delayed 5 cycles, wready immediate -> wvalid high for 1 cycle only;
//    awaddr stable throughout; exactly one bready handshake per write.
//  - bresp=2'b10 on entry 1 -> error=1; no write to 0x108 or 0x010; done pulses.
//  - start pulsed while busy, then aresetn pulsed low mid-WR -> the second start is ignored;
//    after reset busy=0, awvalid=0, wvalid=0.
//  - READBACK_EN, slave returns 0 for entry 2 -> error=1; all count+1 reads are issued; done pulses.

Source files
------------

// File: rtl/video_tbl_writer_pkg.sv
// video_tbl_writer shared package
// register map, state encoding and table address helper
package video_tbl_pkg;

  localparam int REGADR_CORE_ID   = 0;
  localparam int REGADR_PARAM_END = 4;
  localparam int REGADR_PARAM_INV = 5;

  function automatic int regadr_tbl_start(
    input int addr_bits
  );
    return 1 << addr_bits;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WB,
    RA,
    RD,
    FIN
  } state_t;

endpackage

// File: rtl/video_tbl_writer_if.sv
// AXI4-Lite bus bundle used by video_tbl_writer
// m: initiator side, s: target side
interface jelly3_axi4l_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = DATA_BITS / 8
) (
  input logic aresetn,
  input logic aclk
);

  logic [ADDR_BITS-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_BITS-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport m (
    input  aresetn,
    input  aclk,
    output awaddr,
    output awprot,
    output awvalid,
    input  awready,
    output wdata,
    output wstrb,
    output wvalid,
    input  wready,
    input  bresp,
    input  bvalid,
    output bready,
    output araddr,
    output arprot,
    output arvalid,
    input  arready,
    input  rdata,
    input  rresp,
    input  rvalid,
    output rready
  );

  modport s (
    input  aresetn,
    input  aclk,
    input  awaddr,
    input  awprot,
    input  awvalid,
    output awready,
    input  wdata,
    input  wstrb,
    input  wvalid,
    output wready,
    output bresp,
    output bvalid,
    input  bready,
    input  araddr,
    input  arprot,
    input  arvalid,
    output arready,
    output rdata,
    output rresp,
    output rvalid,
    input  rready
  );

endinterface

// File: rtl/video_tbl_writer_ramp_gen.sv
// saturating ramp value generator
// load restarts the ramp, adv steps it and clamps at all ones
module video_tbl_ramp_gen #(
  parameter int VALUE_BITS = 8
) (
  input  logic                  aresetn,
  input  logic                  aclk,
  input  logic                  load,
  input  logic [VALUE_BITS-1:0] load_val,
  input  logic                  adv,
  input  logic [VALUE_BITS-1:0] step,
  output logic [VALUE_BITS-1:0] val
);

  logic [VALUE_BITS:0] sum;

  assign sum = {1'b0, val} + {1'b0, step};

  // ramp register: load wins over advance
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (adv) begin
      val <= sum[VALUE_BITS] ? '1 : sum[VALUE_BITS-1:0];
    end
  end

endmodule

// File: rtl/video_tbl_writer.sv
// AXI4-Lite initiator that loads a ramp table, then PARAM_END
// optional readback verify: VIDEO_TBL_WRITER_READBACK_EN
module video_tbl_writer
  import video_tbl_pkg::*;
#(
  parameter int ADDR_BITS     = 6,
  parameter int MEM_DEPTH     = 2 ** ADDR_BITS,
  parameter int VALUE_BITS    = 8,
  parameter int BASE_ADDR     = 0,
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_DATA_BITS = 32
) (
  input  logic                  aresetn,
  input  logic                  aclk,
  input  logic                  start,
  input  logic [VALUE_BITS-1:0] cfg_base,
  input  logic [VALUE_BITS-1:0] cfg_step,
  input  logic [ADDR_BITS-1:0]  cfg_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  jelly3_axi4l_if.m             m_axi4l
);

  localparam int STRB_BITS = AXI_DATA_BITS / 8;
  localparam int SHIFT     = $clog2(STRB_BITS);

  typedef logic [AXI_ADDR_BITS-1:0] addr_t;
  typedef logic [AXI_DATA_BITS-1:0] data_t;
  typedef logic [ADDR_BITS-1:0]     idx_t;

  localparam addr_t BASE    = addr_t'(BASE_ADDR);
  localparam addr_t TBL_OFS =
    addr_t'(regadr_tbl_start(ADDR_BITS) * STRB_BITS);
  localparam addr_t END_OFS =
    addr_t'(REGADR_PARAM_END * STRB_BITS);
  localparam idx_t  IDX_MAX = idx_t'(MEM_DEPTH - 1);

  state_t state, state_n;
  idx_t   idx, idx_n;
  idx_t   count_r;
  logic   end_ph, end_ph_n;
  logic   awv, awv_n;
  logic   wv, wv_n;
  logic   brdy, brdy_n;
  logic   arv, arv_n;
  logic   rrdy, rrdy_n;
  logic   err, err_n;
  logic   latch;

  logic [VALUE_BITS-1:0] base_r;
  logic [VALUE_BITS-1:0] step_r;
  logic [VALUE_BITS-1:0] val;
  logic                  rg_load;
  logic [VALUE_BITS-1:0] rg_load_val;
  logic                  rg_adv;

  addr_t tbl_addr;

  video_tbl_ramp_gen #(
    .VALUE_BITS (VALUE_BITS)
  ) u_ramp (
    .aresetn  (aresetn),
    .aclk     (aclk),
    .load     (rg_load),
    .load_val (rg_load_val),
    .adv      (rg_adv),
    .step     (step_r),
    .val      (val)
  );

  assign tbl_addr = BASE + TBL_OFS + (addr_t'(idx) << SHIFT);

  assign m_axi4l.awaddr  = end_ph ? BASE + END_OFS : tbl_addr;
  assign m_axi4l.awprot  = 3'b000;
  assign m_axi4l.awvalid = awv;
  assign m_axi4l.wdata   = end_ph ? data_t'(count_r)
                                  : data_t'(val);
  assign m_axi4l.wstrb   = '1;
  assign m_axi4l.wvalid  = wv;
  assign m_axi4l.bready  = brdy;
  assign m_axi4l.arprot  = 3'b000;
  assign m_axi4l.arvalid = arv;
  assign m_axi4l.rready  = rrdy;

`ifdef VIDEO_TBL_WRITER_READBACK_EN
  assign m_axi4l.araddr = tbl_addr;
`else
  assign m_axi4l.araddr = '0;
`endif

  logic unused_bus;
  assign unused_bus = ^{m_axi4l.aresetn,
                        m_axi4l.aclk,
                        m_axi4l.arready,
                        m_axi4l.rvalid,
                        m_axi4l.rresp,
                        m_axi4l.rdata};

  assign busy  = (state != IDLE) && (state != FIN);
  assign done  = (state == FIN);
  assign error = err;

  // config capture on an accepted start, count clamped to table
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      base_r  <= '0;
      step_r  <= '0;
      count_r <= '0;
    end else if (latch) begin
      base_r  <= cfg_base;
      step_r  <= cfg_step;
      count_r <= (cfg_count > IDX_MAX) ? IDX_MAX : cfg_count;
    end
  end

  // sequencer state and channel handshake registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      idx    <= '0;
      end_ph <= 1'b0;
      awv    <= 1'b0;
      wv     <= 1'b0;
      brdy   <= 1'b0;
      arv    <= 1'b0;
      rrdy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      end_ph <= end_ph_n;
      awv    <= awv_n;
      wv     <= wv_n;
      brdy   <= brdy_n;
      arv    <= arv_n;
      rrdy   <= rrdy_n;
      err    <= err_n;
    end
  end

  // next state, channel valids and ramp control
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    end_ph_n    = end_ph;
    awv_n       = awv;
    wv_n        = wv;
    brdy_n      = brdy;
    arv_n       = arv;
    rrdy_n      = rrdy;
    err_n       = err;
    latch       = 1'b0;
    rg_load     = 1'b0;
    rg_load_val = base_r;
    rg_adv      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          latch       = 1'b1;
          err_n       = 1'b0;
          idx_n       = '0;
          end_ph_n    = 1'b0;
          rg_load     = 1'b1;
          rg_load_val = cfg_base;
          awv_n       = 1'b1;
          wv_n        = 1'b1;
          state_n     = WR;
        end
      end
      WR: begin
        if (awv && m_axi4l.awready) awv_n = 1'b0;
        if (wv && m_axi4l.wready)   wv_n  = 1'b0;
        if ((!awv || m_axi4l.awready) &&
            (!wv || m_axi4l.wready)) begin
          brdy_n  = 1'b1;
          state_n = WB;
        end
      end
      WB: begin
        if (m_axi4l.bvalid) begin
          brdy_n = 1'b0;
          if (m_axi4l.bresp != 2'b00) begin
            err_n   = 1'b1;
            state_n = FIN;
          end else if (!end_ph) begin
            if (idx < count_r) begin
              idx_n  = idx + 1'b1;
              rg_adv = 1'b1;
            end else begin
              end_ph_n = 1'b1;
            end
            awv_n   = 1'b1;
            wv_n    = 1'b1;
            state_n = WR;
          end else begin
`ifdef VIDEO_TBL_WRITER_READBACK_EN
            end_ph_n = 1'b0;
            idx_n    = '0;
            rg_load  = 1'b1;
            arv_n    = 1'b1;
            state_n  = RA;
`else
            state_n  = FIN;
`endif
          end
        end
      end
`ifdef VIDEO_TBL_WRITER_READBACK_EN
      RA: begin
        if (m_axi4l.arready) begin
          arv_n   = 1'b0;
          rrdy_n  = 1'b1;
          state_n = RD;
        end
      end
      RD: begin
        if (m_axi4l.rvalid) begin
          rrdy_n = 1'b0;
          if (m_axi4l.rresp != 2'b00 ||
              m_axi4l.rdata[VALUE_BITS-1:0] != val) begin
            err_n = 1'b1;
          end
          if (idx < count_r) begin
            idx_n   = idx + 1'b1;
            rg_adv  = 1'b1;
            arv_n   = 1'b1;
            state_n = RA;
          end else begin
            state_n = FIN;
          end
        end
      end
`endif
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_video_tbl_writer.sv
// directed bench for video_tbl_writer with a behavioural AXI4-Lite target
// honours VIDEO_TBL_WRITER_READBACK_EN
`timescale 1ns/1ps
module tb_video_tbl_writer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_base = '0;
  logic [7:0] cfg_step = '0;
  logic [5:0] cfg_count = '0;
  logic       busy, done, error;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  jelly3_axi4l_if #(
    .ADDR_BITS (32),
    .DATA_BITS (32)
  ) axi (
    .aresetn (aresetn),
    .aclk    (aclk)
  );

  video_tbl_writer #(
    .ADDR_BITS     (6),
    .VALUE_BITS    (8),
    .BASE_ADDR     (0),
    .AXI_ADDR_BITS (32),
    .AXI_DATA_BITS (32)
  ) dut (
    .aresetn   (aresetn),
    .aclk      (aclk),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_step  (cfg_step),
    .cfg_count (cfg_count),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .m_axi4l   (axi)
  );

`ifdef VIDEO_TBL_WRITER_READBACK_EN
  localparam int LAT_BASIC = 19;
`else
  localparam int LAT_BASIC = 11;
`endif

  int          aw_dly = 0;
  int          w_dly = 0;
  int          err_wr = -1;
  logic [31:0] bad_rd_addr = 32'hFFFF_FFFF;

  int          aw_wait, w_wait;
  logic        aw_got, w_got;
  logic [31:0] a_addr, w_dat;
  logic [31:0] wr_addr [256];
  logic [31:0] wr_data [256];
  logic [31:0] rd_addr [256];
  logic [31:0] mem [128];
  int          wr_cnt = 0;
  int          b_cnt = 0;
  int          rd_cnt = 0;
  int          wv_cyc = 0;
  int          ar_cyc = 0;
  int          unstable = 0;
  logic        aw_pend = 1'b0;
  logic [31:0] aw_prev = '0;

  assign axi.awready = axi.awvalid && !aw_got &&
                       !axi.bvalid && (aw_wait >= aw_dly);
  assign axi.wready  = axi.wvalid && !w_got &&
                       !axi.bvalid && (w_wait >= w_dly);
  assign axi.arready = axi.arvalid && !axi.rvalid;

  // behavioural target: logs writes, answers B and R
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_wait    <= 0;
      w_wait     <= 0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      axi.rresp  <= 2'b00;
      axi.rdata  <= '0;
    end else begin
      logic [31:0] ad;
      logic [31:0] dt;
      ad = aw_got ? a_addr : axi.awaddr;
      dt = w_got ? w_dat : axi.wdata;
      if (axi.awvalid && !axi.awready && !aw_got)
        aw_wait <= aw_wait + 1;
      if (axi.wvalid && !axi.wready && !w_got)
        w_wait <= w_wait + 1;
      if (axi.awvalid && axi.awready) begin
        aw_got  <= 1'b1;
        a_addr  <= axi.awaddr;
        aw_wait <= 0;
      end
      if (axi.wvalid && axi.wready) begin
        w_got  <= 1'b1;
        w_dat  <= axi.wdata;
        w_wait <= 0;
      end
      if ((aw_got || (axi.awvalid && axi.awready)) &&
          (w_got || (axi.wvalid && axi.wready)) &&
          !axi.bvalid) begin
        wr_addr[wr_cnt[7:0]] <= ad;
        wr_data[wr_cnt[7:0]] <= dt;
        mem[ad[8:2]]         <= dt;
        axi.bresp  <= (wr_cnt == err_wr) ? 2'b10 : 2'b00;
        axi.bvalid <= 1'b1;
        wr_cnt     <= wr_cnt + 1;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
        b_cnt      <= b_cnt + 1;
      end
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        axi.rresp  <= 2'b00;
        axi.rdata  <= (axi.araddr == bad_rd_addr) ?
                      32'd0 : mem[axi.araddr[8:2]];
        rd_addr[rd_cnt[7:0]] <= axi.araddr;
      end
      if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
        rd_cnt     <= rd_cnt + 1;
      end
    end
  end

  // bus monitor: wvalid cycles, read activity, awaddr stability
  always @(posedge aclk) begin
    if (aresetn) begin
      if (axi.wvalid) wv_cyc <= wv_cyc + 1;
      if (axi.arvalid || axi.rready) ar_cyc <= ar_cyc + 1;
      if (axi.awvalid && aw_pend && axi.awaddr != aw_prev)
        unstable <= unstable + 1;
      aw_pend <= axi.awvalid && !axi.awready;
      aw_prev <= axi.awaddr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(
    input logic [7:0] b,
    input logic [7:0] s,
    input logic [5:0] c
  );
    @(negedge aclk);
    cfg_base  = b;
    cfg_step  = s;
    cfg_count = c;
    start     = 1'b1;
    @(negedge aclk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < max) begin
      @(negedge aclk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({busy, done, error, axi.awvalid, axi.wvalid,
         axi.bready, axi.arvalid, axi.rready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {busy, done, error, axi.awvalid, axi.wvalid,
                axi.bready, axi.arvalid, axi.rready});
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic;
    logic [31:0] ea [5];
    logic [31:0] ed [5];
    int w0, b0, r0, cyc;
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h010};
    ed = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd3};
    w0 = wr_cnt;
    b0 = b_cnt;
    r0 = rd_cnt;
    pulse_start(8'd0, 8'd4, 6'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    wait_done(200, cyc);
    checks++;
    if (done !== 1'b1 || cyc != LAT_BASIC) begin
      errors++;
      $display("FAIL basic_latency: done=%b cyc=%0d want %0d",
               done, cyc, LAT_BASIC);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0",
               done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_addr[w0+i] !== ea[i] || wr_data[w0+i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got %h/%0d want %h/%0d",
                 i, wr_addr[w0+i], wr_data[w0+i], ea[i], ed[i]);
      end
    end
    checks++;
    if (wr_cnt - w0 != 5 || b_cnt - b0 != 5) begin
      errors++;
      $display("FAIL basic_counts: wr=%0d b=%0d want 5 5",
               wr_cnt - w0, b_cnt - b0);
    end
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL basic_error: got %b want 0", error);
    end
`ifdef VIDEO_TBL_WRITER_READBACK_EN
    checks++;
    if (rd_cnt - r0 != 4) begin
      errors++;
      $display("FAIL basic_reads: got %0d want 4", rd_cnt - r0);
    end
`else
    checks++;
    if (rd_cnt != r0) begin
      errors++;
      $display("FAIL basic_reads: got %0d want 0", rd_cnt - r0);
    end
`endif
  endtask

  task automatic test_saturate;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    int w0, cyc;
    ea = '{32'h100, 32'h104, 32'h108, 32'h010};
    ed = '{32'd250, 32'd253, 32'd255, 32'd2};
    w0 = wr_cnt;
    pulse_start(8'd250, 8'd3, 6'd2);
    wait_done(200, cyc);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || wr_cnt - w0 != 4) begin
      errors++;
      $display("FAIL sat_end: done=%b err=%b wr=%0d want 1 0 4",
               done, error, wr_cnt - w0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[w0+i] !== ea[i] || wr_data[w0+i] !== ed[i]) begin
        errors++;
        $display("FAIL sat_write%0d: got %h/%0d want %h/%0d",
                 i, wr_addr[w0+i], wr_data[w0+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_channel_skew;
    int w0, b0, v0, u0, cyc;
    w0 = wr_cnt;
    b0 = b_cnt;
    v0 = wv_cyc;
    u0 = unstable;
    aw_dly = 5;
    pulse_start(8'd0, 8'd1, 6'd0);
    wait_done(200, cyc);
    aw_dly = 0;
    checks++;
    if (done !== 1'b1 || wv_cyc - v0 != 2) begin
      errors++;
      $display("FAIL aw_late_wvalid: done=%b wv_cyc=%0d want 1 2",
               done, wv_cyc - v0);
    end
    checks++;
    if (unstable != u0) begin
      errors++;
      $display("FAIL aw_late_addr: changes=%0d want 0",
               unstable - u0);
    end
    checks++;
    if (wr_cnt - w0 != 2 || b_cnt - b0 != 2 ||
        wr_addr[w0+1] !== 32'h010) begin
      errors++;
      $display("FAIL aw_late_b: wr=%0d b=%0d a1=%h want 2 2 010",
               wr_cnt - w0, b_cnt - b0, wr_addr[w0+1]);
    end
    w0 = wr_cnt;
    b0 = b_cnt;
    w_dly = 4;
    pulse_start(8'd7, 8'd1, 6'd1);
    wait_done(200, cyc);
    w_dly = 0;
    checks++;
    if (done !== 1'b1 || wr_cnt - w0 != 3 || b_cnt - b0 != 3) begin
      errors++;
      $display("FAIL w_late_b: done=%b wr=%0d b=%0d want 1 3 3",
               done, wr_cnt - w0, b_cnt - b0);
    end
    checks++;
    if (wr_data[w0] !== 32'd7 || wr_data[w0+1] !== 32'd8 ||
        wr_data[w0+2] !== 32'd1) begin
      errors++;
      $display("FAIL w_late_data: got %0d %0d %0d want 7 8 1",
               wr_data[w0], wr_data[w0+1], wr_data[w0+2]);
    end
  endtask

  task automatic test_bresp_error;
    int w0, b0, hits, cyc;
    w0 = wr_cnt;
    b0 = b_cnt;
    err_wr = wr_cnt + 1;
    pulse_start(8'd0, 8'd4, 6'd3);
    wait_done(200, cyc);
    err_wr = -1;
    checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL bresp_end: done=%b err=%b want 1 1",
               done, error);
    end
    hits = 0;
    for (int i = w0; i < wr_cnt; i++)
      if (wr_addr[i] == 32'h108 || wr_addr[i] == 32'h010) hits++;
    checks++;
    if (wr_cnt - w0 != 2 || b_cnt - b0 != 2 || hits != 0) begin
      errors++;
      $display("FAIL bresp_stop: wr=%0d b=%0d hits=%0d want 2 2 0",
               wr_cnt - w0, b_cnt - b0, hits);
    end
    @(negedge aclk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bresp_sticky: err=%b busy=%b want 1 0",
               error, busy);
    end
  endtask

  task automatic test_busy_reset;
    int w0, n;
    w0 = wr_cnt;
    pulse_start(8'd0, 8'd1, 6'd5);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_err: got %b want 0", error);
    end
    @(negedge aclk);
    cfg_base = 8'd100;
    start    = 1'b1;
    @(negedge aclk);
    start    = 1'b0;
    n = 0;
    while (wr_cnt - w0 < 2 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    aw_dly = 10;
    n = 0;
    while (axi.awvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (axi.awvalid !== 1'b1 || wr_data[w0] !== 32'd0 ||
        wr_data[w0+1] !== 32'd1) begin
      errors++;
      $display("FAIL busy_start_ignored: awv=%b d=%0d %0d want 1 0 1",
               axi.awvalid, wr_data[w0], wr_data[w0+1]);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, axi.awvalid, axi.wvalid, axi.bready}
        !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset: got %b want 00000",
               {busy, done, axi.awvalid, axi.wvalid, axi.bready});
    end
    aw_dly = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

`ifdef VIDEO_TBL_WRITER_READBACK_EN
  task automatic test_readback;
    int r0, cyc;
    r0 = rd_cnt;
    bad_rd_addr = 32'h108;
    pulse_start(8'd0, 8'd4, 6'd3);
    wait_done(300, cyc);
    bad_rd_addr = 32'hFFFF_FFFF;
    checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL rb_error: done=%b err=%b want 1 1",
               done, error);
    end
    checks++;
    if (rd_cnt - r0 != 4 || rd_addr[r0+3] !== 32'h10C) begin
      errors++;
      $display("FAIL rb_reads: n=%0d last=%h want 4 10C",
               rd_cnt - r0, rd_addr[r0+3]);
    end
  endtask
`else
  task automatic test_tieoff;
    checks++;
    if (ar_cyc != 0) begin
      errors++;
      $display("FAIL read_tieoff: active cycles=%0d want 0",
               ar_cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_channel_skew();
    test_bresp_error();
    test_busy_reset();
`ifdef VIDEO_TBL_WRITER_READBACK_EN
    test_readback();
`else
    test_tieoff();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
